// File: rtl/acq_pkg.sv
// Shared types and host command codes for the acquisition sequencer.
// The state enum and command constants are used by the decoder and the sequencer.
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } acq_state_t;

    localparam logic [7:0] CMD_ARM     = 8'h41;  // 'A'
    localparam logic [7:0] CMD_ABORT   = 8'h58;  // 'X'
    localparam logic [7:0] CMD_TRIGSRC = 8'h54;  // 'T'
    localparam logic [7:0] CMD_SLOPE   = 8'h53;  // 'S'
    localparam logic [7:0] CMD_DELAY   = 8'h44;  // 'D'
    localparam logic [7:0] CMD_CONT    = 8'h43;  // 'C'

    // One-hot, single-cycle command strobes from the decoder.
    typedef struct packed {
        logic arm;
        logic abort;
        logic trigsrc;
        logic slope;
        logic delay;
        logic cont;
    } acq_cmd_t;

endpackage

// File: rtl/acq_if.sv
// Waveform buffer write port plus the ready/ack handshake with the readout sampler.
// The sequencer is the master; the buffer/readout side is the slave.
interface acq_if #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned SAMPLE_W = 14
);
    logic                wrEn;
    logic [ADDR_W-1:0]   wrAddr;
    logic [SAMPLE_W-1:0] wrData;
    logic                ready;
    logic                ack;
    logic [15:0]         waveNumber;

    modport master (
        output wrEn, wrAddr, wrData, ready, waveNumber,
        input  ack
    );

    modport slave (
        input  wrEn, wrAddr, wrData, ready, waveNumber,
        output ack
    );
endinterface

// File: rtl/acq_cmd_decode.sv
// Host command decoder: two-register synchroniser, stability compare and last-command memory.
// Emits one-cycle strobes, combinationally, on the edge a new stable character is accepted.
module acq_cmd_decode
    import acq_pkg::*;
#(
    parameter int unsigned CMD_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] cmdChar,
    output acq_cmd_t         cmd
);

    logic [CMD_W-1:0] s1;
    logic [CMD_W-1:0] s2;
    logic [CMD_W-1:0] last_cmd;
    logic             accept;

    // The strobe is asserted on the same edge that loads last_cmd, so it lasts one cycle.
    assign accept = (s1 == s2) && (s2 != last_cmd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            last_cmd <= '0;
        end else begin
            s1 <= cmdChar;
            s2 <= s1;
            if (accept) begin
                last_cmd <= s2;
            end
        end
    end

    always_comb begin
        cmd = '0;
        if (accept) begin
            cmd.arm     = (s2 == CMD_W'(CMD_ARM));
            cmd.abort   = (s2 == CMD_W'(CMD_ABORT));
            cmd.trigsrc = (s2 == CMD_W'(CMD_TRIGSRC));
            cmd.slope   = (s2 == CMD_W'(CMD_SLOPE));
            cmd.delay   = (s2 == CMD_W'(CMD_DELAY));
            cmd.cont    = (s2 == CMD_W'(CMD_CONT));
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// ADC capture sequencer: arm, trigger wait, fixed-length buffer write, readout handshake.
// Owns the trigger/delay configuration bits and the completed-waveform counter.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 14,
    parameter int unsigned DEPTH    = 1000,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CMD_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CMD_W-1:0]    cmdChar,
    input  logic                trigger,
    input  logic [SAMPLE_W-1:0] sampleIn,
    output logic                trigSource,
    output logic                trigSlope,
    output logic                delaySel,
    output logic                armed,
    acq_if.master               bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    acq_cmd_t            cmd;
    acq_state_t          state;
    logic                cont_mode;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                ready_r;
    logic [15:0]         wave_cnt;
    logic                cfg_ok;

    acq_cmd_decode #(
        .CMD_W(CMD_W)
    ) u_cmd_decode (
        .clk    (clk),
        .reset  (reset),
        .cmdChar(cmdChar),
        .cmd    (cmd)
    );

    // Configuration may only change while no capture is pending or running.
    assign cfg_ok = (state == IDLE) || (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cont_mode  <= 1'b0;
            trigSource <= 1'b0;
            trigSlope  <= 1'b0;
            delaySel   <= 1'b0;
            armed      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            ready_r    <= 1'b0;
            wave_cnt   <= '0;
        end else if (cmd.abort) begin
            // Abort overrides a coincident trigger or final write; the counter is untouched.
            state   <= IDLE;
            armed   <= 1'b0;
            wr_en   <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            if (cfg_ok) begin
                if (cmd.trigsrc) trigSource <= ~trigSource;
                if (cmd.slope)   trigSlope  <= ~trigSlope;
                if (cmd.delay)   delaySel   <= ~delaySel;
                if (cmd.cont)    cont_mode  <= ~cont_mode;
            end

            unique case (state)
                IDLE: begin
                    if (cmd.arm) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end

                ARMED: begin
                    if (trigger) begin
                        state   <= CAPTURE;
                        armed   <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= sampleIn;
                    end
                end

                CAPTURE: begin
                    wr_data <= sampleIn;
                    if (wr_addr == LAST_ADDR) begin
                        state    <= DONE;
                        wr_en    <= 1'b0;
                        ready_r  <= 1'b1;
                        wave_cnt <= wave_cnt + 16'd1;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end

                DONE: begin
                    if (bus.ack) begin
                        ready_r <= 1'b0;
                        if (cont_mode) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wrEn       = wr_en;
    assign bus.wrAddr     = wr_addr;
    assign bus.wrData     = wr_data;
    assign bus.ready      = ready_r;
    assign bus.waveNumber = wave_cnt;

endmodule
